// File: rtl/alu_sequencer.sv
// Command-bus initiator for the ALU: sequences latch/output commands for one
// request at a time and returns the captured result over a valid/ready port.
module alu_sequencer #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [FLAG_W-1:0] req_flags,
  output logic [3:0]        alu_cmd,
  output logic [WIDTH-1:0]  alu_bus_out,
  output logic              alu_bus_oe,
  input  logic [WIDTH-1:0]  alu_bus_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_y,
  output logic [FLAG_W-1:0] rsp_f,
  output logic              rsp_err
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    IDLE, LATCH_A, LATCH_B, LATCH_F, LATCH_OP, OUT_Y, WAIT_Y, OUT_F, WAIT_F, RESP
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rsp_y_q, rsp_y_d;
  logic [FLAG_W-1:0]  rsp_f_q, rsp_f_d;
  logic               rsp_err_q, rsp_err_d;
  logic               needs_b, needs_f;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    rsp_y_d     = rsp_y_q;
    rsp_f_d     = rsp_f_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    alu_cmd     = 4'd0;
    alu_bus_out = '0;
    alu_bus_oe  = 1'b0;
    rsp_valid   = 1'b0;
    // Unary ops (INC, DEC, LSH, RSH) never need operand B; only ADC/SBC consume input flags.
    needs_b     = !(op_q inside {4'h4, 4'h5, 4'hB, 4'hC});
    needs_f     = op_q inside {4'h1, 4'h2};

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d      = req_op;
          a_d       = req_a;
          b_d       = req_b;
          flags_d   = req_flags;
          rsp_y_d   = '0;
          rsp_f_d   = '0;
          rsp_err_d = (req_op >= 4'hD);
          state_d   = (req_op >= 4'hD) ? RESP : LATCH_A;
        end
      end
      LATCH_A: begin
        alu_cmd     = 4'd1;
        alu_bus_out = a_q;
        alu_bus_oe  = 1'b1;
        state_d     = needs_b ? LATCH_B : LATCH_OP;
      end
      LATCH_B: begin
        alu_cmd     = 4'd2;
        alu_bus_out = b_q;
        alu_bus_oe  = 1'b1;
        state_d     = needs_f ? LATCH_F : LATCH_OP;
      end
      LATCH_F: begin
        alu_cmd                  = 4'd3;
        alu_bus_out[FLAG_W-1:0]  = flags_q;
        alu_bus_oe               = 1'b1;
        state_d                  = LATCH_OP;
      end
      LATCH_OP: begin
        alu_cmd          = 4'd4;
        alu_bus_out[3:0] = op_q;
        alu_bus_oe       = 1'b1;
        state_d          = OUT_Y;
      end
      OUT_Y: begin
        alu_cmd = 4'd5;
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = WAIT_Y;
      end
      WAIT_Y: begin
        if (cnt_q == '0) begin
          rsp_y_d = alu_bus_in;
          state_d = OUT_F;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT_F: begin
        alu_cmd = 4'd6;
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = WAIT_F;
      end
      WAIT_F: begin
        if (cnt_q == '0) begin
          rsp_f_d = alu_bus_in[FLAG_W-1:0];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      flags_q   <= '0;
      cnt_q     <= '0;
      rsp_y_q   <= '0;
      rsp_f_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      rsp_y_q   <= rsp_y_d;
      rsp_f_q   <= rsp_f_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_y   = rsp_y_q;
  assign rsp_f   = rsp_f_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-bus initiator for the ALU. It accepts one operation request (opcode, operands, input flags) from the CPU control path and issues the ALU command sequence: latch A, latch B, latch F, latch Op, output Y, output F. It captures the result word and result flags from the shared ALU bus and returns them through a valid/ready response port. One operation is in flight at a time.

## Interface
- WIDTH, 16, data/operand width; must be ≥ FLAG_W and ≥ 4.
- FLAG_W, 8, flag vector width; bits 0–6 are carry, zero, equal, greater, less, borrow, rfu.
- RD_LAT, 1, cycles from an output command to valid data on alu_bus_in; must be ≥ 1.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; the request is accepted on req_valid && req_ready.
- req_op  in  4  ALU opcode (ADD=0x0 … RSH=0xC).
- req_a, req_b  in  WIDTH  operands.
- req_flags  in  FLAG_W  input flags (carry used by ADC/SBC).
- alu_cmd  out  4  ALU command; 0 = NOP, 1 latchA, 2 latchB, 3 latchF, 4 latchOp, 5 outputY, 6 outputF.
- alu_bus_out  out  WIDTH  data driven to the ALU during latch commands.
- alu_bus_oe  out  1  high while alu_bus_out is being driven.
- alu_bus_in  in  WIDTH  ALU output data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  WIDTH  result word.
- rsp_f  out  FLAG_W  result flags (alu_bus_in[FLAG_W-1:0]).
- rsp_err  out  1  opcode was unsupported (≥ 0xD).

## Operation
- States: IDLE, LATCH_A, LATCH_B, LATCH_F, LATCH_OP, OUT_Y, WAIT_Y, OUT_F, WAIT_F, RESP.
- IDLE: req_ready=1 and alu_cmd=0. On acceptance, register op/a/b/flags so the req_* inputs may change afterwards.
- Accepted op ≥ 0xD: go directly to RESP with rsp_err=1, rsp_y=0, rsp_f=0. No ALU command is issued.
- Otherwise the next state is LATCH_A.
- LATCH_A: alu_cmd=1, alu_bus_out=a.
- LATCH_B: alu_cmd=2, alu_bus_out=b. Skipped for INC, DEC, LSH, RSH (0x4, 0x5, 0xB, 0xC).
- LATCH_F: alu_cmd=3, alu_bus_out=zero-extended flags. Entered only for ADC and SBC (0x1, 0x2).
- LATCH_OP: alu_cmd=4, alu_bus_out=zero-extended op.
- alu_bus_oe=1 in the LATCH_* states only. Outside them, alu_bus_out=0.
- OUT_Y: alu_cmd=5 for 1 cycle.
- WAIT_Y: alu_cmd=0 for RD_LAT cycles, counted by a down-counter. rsp_y ← alu_bus_in on the edge that ends the last WAIT_Y cycle.
- OUT_F / WAIT_F: same pattern with alu_cmd=6, capturing rsp_f ← alu_bus_in[FLAG_W-1:0]. After WAIT_F the FSM goes to RESP.
- RESP: rsp_valid=1, and rsp_y/rsp_f/rsp_err are held stable. When rsp_ready=1, go to IDLE.
- A new request is never accepted in the RESP cycle.
- rsp_y/rsp_f/rsp_err keep their last values in IDLE and are cleared when the next request is accepted.

## Timing
- Cycle 0 is the cycle of acceptance. Commands then follow at one per cycle with no gaps.
- N = number of latch states (2, 3 or 4). rsp_valid first rises in cycle N+3+2·RD_LAT.
- With RD_LAT=1:
  - ADD/SBC-free binary op (N=3): rsp_valid in cycle 8.
  - INC (N=2): rsp_valid in cycle 7.
  - ADC (N=4): rsp_valid in cycle 9.
  - Unsupported op: rsp_valid in cycle 1.
- req_ready is 0 from cycle 1 until the cycle after the RESP handshake.
- Reset values: FSM in IDLE, req_ready=1 in the first cycle after reset, alu_cmd=0, alu_bus_out=0, alu_bus_oe=0, rsp_valid=0, rsp_y=0, rsp_f=0, rsp_err=0, counter=0.
- Reset mid-operation aborts with no response: alu_cmd=0 and alu_bus_oe=0 from the next cycle, and the captured results are cleared.
- req_valid together with reset: the request is ignored.

## Test plan
- ADD, a=0x1234, b=0x0FFF, bench ALU returns Y=0x2233, F=0x00 -> alu_cmd trace 1,2,4,5,0,6,0 in cycles 1–7; rsp_valid in cycle 8 with rsp_y=0x2233, rsp_err=0.
- ADC, a=0xFFFF, b=0x0000, flags=0x01, model returns Y=0x0000, F=0x03 -> trace 1,2,3,4,5,0,6,0; alu_bus_out=0x0001 during cmd 3; rsp_f=0x03 in cycle 9.
- INC, a=0x00FF -> trace 1,4,5,0,6,0 (no cmd 2); rsp_y=0x0100 in cycle 7.
- Opcode 0xD -> alu_cmd stays 0 throughout; rsp_valid=1, rsp_err=1, rsp_y=0 in cycle 1.
- rsp_ready held low for 5 cycles in RESP -> rsp_* stable, req_ready=0, alu_cmd=0; IDLE on the cycle after rsp_ready=1.
- Reset asserted while alu_cmd=2 -> alu_cmd=0 and rsp_valid=0 the next cycle, req_ready=1 after reset. Then with RD_LAT=3, ADD -> rsp_valid in cycle 12.
